uart_tx_fifo: RTL and testbench

Buffered, runtime-configurable UART transmitter for the PWM-generator control path. It accepts bytes over a valid/ready stream into an internal FIFO and serialises them LSB-first. Frame format is selectable per frame: 5–8 data bits, none/even/odd parity, and 1 or 2 stop bits. The baud divisor is programmable, and frames are sent back-to-back while the FIFO is non-empty.

---
 rtl/uart_tx_fifo.sv | 144 ++++++++++++++
 tb/tb_uart_tx_fifo.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter with per-frame data/parity/stop and baud configuration
module uart_tx_fifo #(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD_RATE  = 115200,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          clk_50mhz,
   input  logic                          rst_n,
   input  logic                          s_valid,
   output logic                          s_ready,
   input  logic [7:0]                    s_data,
   input  logic [3:0]                    cfg_data_bits,
   input  logic [1:0]                    cfg_parity,
   input  logic                          cfg_stop2,
   input  logic [15:0]                   cfg_baud_div,
   output logic                          tx_out,
   output logic                          tx_busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0]   FULL    = (AW+1)'(FIFO_DEPTH);
   localparam logic [AW:0]   C_ONE   = (AW+1)'(1);
   localparam logic [AW-1:0] P_ONE   = AW'(1);
   localparam logic [15:0]   DEF_DIV = 16'(CLK_FREQ / BAUD_RATE);
   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] START  = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
   localparam logic [2:0] PARITY = 3'd3;
   localparam logic [2:0] STOP   = 3'd4;

   logic [7:0]    r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wr_ptr, r_rd_ptr;
   logic [AW:0]   r_count;
   logic [2:0]    r_state;
   logic [15:0]   r_div, r_bit_cnt;
   logic [7:0]    r_shift;
   logic [3:0]    r_nbits, r_bit_idx;
   logic          r_par_en, r_par, r_stop2, r_stop_idx, r_tx;
   logic          w_push, w_pop, w_end, w_last_stop;
   logic [3:0]    w_nbits;
   logic [15:0]   w_div;
   logic [7:0]    w_head, w_mask;

   assign s_ready    = r_count != FULL;
   assign tx_out     = r_tx;
   assign tx_busy    = r_state != IDLE || r_count != '0;
   assign fifo_count = r_count;

   always_comb begin
      w_nbits     = cfg_data_bits < 4'd5 ? 4'd5 : cfg_data_bits > 4'd8 ? 4'd8 : cfg_data_bits;
      w_div       = cfg_baud_div == 16'd0 ? DEF_DIV : cfg_baud_div == 16'd1 ? 16'd2 : cfg_baud_div;
      w_mask      = 8'hFF >> (4'd8 - w_nbits);
      w_head      = r_mem[r_rd_ptr];
      w_end       = r_bit_cnt == r_div - 16'd1;
      w_last_stop = r_state == STOP && w_end && (!r_stop2 || r_stop_idx);
      w_push      = s_valid && s_ready;
      w_pop       = r_count != '0 && (r_state == IDLE || w_last_stop);
   end

   always_ff @(posedge clk_50mhz) begin
      if (w_push) r_mem[r_wr_ptr] <= s_data;
   end

   always_ff @(posedge clk_50mhz or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + P_ONE;
         if (w_pop) r_rd_ptr <= r_rd_ptr + P_ONE;
         if (w_push != w_pop) r_count <= w_push ? r_count + C_ONE : r_count - C_ONE;
      end
   end

   // A pop always starts a frame, whether from IDLE or straight out of the last stop cell
   always_ff @(posedge clk_50mhz or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_tx       <= 1'b1;
         r_div      <= DEF_DIV;
         r_bit_cnt  <= '0;
         r_shift    <= '0;
         r_nbits    <= 4'd8;
         r_bit_idx  <= '0;
         r_par_en   <= 1'b0;
         r_par      <= 1'b0;
         r_stop2    <= 1'b0;
         r_stop_idx <= 1'b0;
      end else if (w_pop) begin
         r_state    <= START;
         r_tx       <= 1'b0;
         r_bit_cnt  <= '0;
         r_div      <= w_div;
         r_shift    <= w_head;
         r_nbits    <= w_nbits;
         r_bit_idx  <= '0;
         r_par_en   <= ^cfg_parity;
         r_par      <= (^(w_head & w_mask)) ^ (cfg_parity == 2'b10);
         r_stop2    <= cfg_stop2;
         r_stop_idx <= 1'b0;
      end else if (r_state == IDLE) begin
         r_tx <= 1'b1;
      end else if (r_state > STOP) begin
         r_state <= IDLE;
         r_tx    <= 1'b1;
      end else if (!w_end) begin
         r_bit_cnt <= r_bit_cnt + 16'd1;
      end else begin
         r_bit_cnt <= '0;
         case (r_state)
            START: begin
               r_tx    <= r_shift[0];
               r_shift <= r_shift >> 1;
               r_state <= DATA;
            end
            DATA: begin
               if (r_bit_idx == r_nbits - 4'd1) begin
                  r_state    <= r_par_en ? PARITY : STOP;
                  r_tx       <= r_par_en ? r_par : 1'b1;
                  r_stop_idx <= 1'b0;
               end else begin
                  r_tx      <= r_shift[0];
                  r_shift   <= r_shift >> 1;
                  r_bit_idx <= r_bit_idx + 4'd1;
               end
            end
            PARITY: begin
               r_state    <= STOP;
               r_tx       <= 1'b1;
               r_stop_idx <= 1'b0;
            end
            default: begin
               if (w_last_stop) begin
                  r_state <= IDLE;
                  r_tx    <= 1'b1;
               end else begin
                  r_stop_idx <= 1'b1;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed self-checking bench for uart_tx_fifo
module tb_uart_tx_fifo;
   logic        clk_50mhz = 1'b0;
   logic        rst_n = 1'b0;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic [7:0]  s_data = '0;
   logic [3:0]  cfg_data_bits = 4'd8;
   logic [1:0]  cfg_parity = 2'b00;
   logic        cfg_stop2 = 1'b0;
   logic [15:0] cfg_baud_div = 16'd4;
   logic        tx_out, tx_busy;
   logic [4:0]  fifo_count;
   int          n_chk = 0;
   int          n_pass = 0;

   uart_tx_fifo dut (
      .clk_50mhz(clk_50mhz), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .cfg_data_bits(cfg_data_bits), .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2),
      .cfg_baud_div(cfg_baud_div), .tx_out(tx_out), .tx_busy(tx_busy), .fifo_count(fifo_count)
   );

   always #10 clk_50mhz = ~clk_50mhz;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk_50mhz);
      #1;
   endtask

   task automatic push(input logic [7:0] b);
      s_valid = 1'b1;
      s_data  = b;
      tick();
      s_valid = 1'b0;
   endtask

   // bits holds the frame with the start bit as the most significant of nb cells
   task automatic check_frame(input string tag, input logic [15:0] bits, input int nb, input int div);
      for (int c = 0; c < nb; c++) begin
         logic ok = 1'b1;
         for (int j = 0; j < div; j++) begin
            if (tx_out !== bits[nb-1-c] || tx_busy !== 1'b1) ok = 1'b0;
            tick();
         end
         chk($sformatf("%s cell%0d", tag, c), ok, 1);
      end
   endtask

   function automatic logic [15:0] f8n1(input logic [7:0] b);
      logic [15:0] f = '0;
      for (int i = 0; i < 8; i++) f[8-i] = b[i];
      f[0] = 1'b1;
      return f;
   endfunction

   initial begin
      repeat (2) tick();
      chk("rst tx", tx_out, 1);
      chk("rst busy", tx_busy, 0);
      chk("rst ready", s_ready, 1);
      chk("rst count", fifo_count, 0);
      rst_n = 1'b1;
      tick();
      chk("post rst tx", tx_out, 1);
      chk("post rst busy", tx_busy, 0);
      chk("post rst count", fifo_count, 0);

      push(8'hA5);
      chk("a5 count after push", fifo_count, 1);
      chk("a5 busy after push", tx_busy, 1);
      chk("a5 tx before pop", tx_out, 1);
      tick();
      chk("a5 count after pop", fifo_count, 0);
      check_frame("8n1 a5", 16'b0101001011, 10, 4);
      chk("a5 busy end", tx_busy, 0);
      chk("a5 tx idle", tx_out, 1);

      cfg_data_bits = 4'd7; cfg_parity = 2'b01; cfg_stop2 = 1'b1;
      push(8'h53);
      tick();
      check_frame("7e2 53", 16'b0_1100101_0_11, 11, 4);
      chk("7e2 busy end", tx_busy, 0);

      cfg_data_bits = 4'd5; cfg_parity = 2'b10; cfg_stop2 = 1'b0;
      push(8'hFF);
      tick();
      check_frame("5o1 ff", 16'b0_11111_0_1, 8, 4);
      chk("5o1 busy end", tx_busy, 0);

      cfg_data_bits = 4'd15; cfg_parity = 2'b11; cfg_baud_div = 16'd1;
      push(8'h0F);
      tick();
      check_frame("clamp 0f", 16'b0_11110000_1, 10, 2);
      chk("clamp busy end", tx_busy, 0);

      cfg_data_bits = 4'd8; cfg_parity = 2'b00; cfg_stop2 = 1'b0; cfg_baud_div = 16'd4;
      push(8'h3C);
      push(8'hC3);
      chk("cfg push+pop count", fifo_count, 1);
      chk("cfg frame1 start", tx_out, 0);
      cfg_stop2 = 1'b1; cfg_baud_div = 16'd8;
      check_frame("cfg f1", f8n1(8'h3C), 10, 4);
      check_frame("cfg f2", (f8n1(8'hC3) << 1) | 16'd1, 11, 8);
      chk("cfg busy end", tx_busy, 0);

      cfg_stop2 = 1'b0; cfg_baud_div = 16'd4;
      fork
         begin
            for (int i = 0; i < 17; i++) begin
               s_valid = 1'b1;
               s_data  = 8'(i);
               tick();
            end
            chk("full count", fifo_count, 16);
            chk("full ready", s_ready, 0);
            s_valid = 1'b1;
            s_data  = 8'hEE;
            tick();
            s_valid = 1'b0;
            chk("full refuse count", fifo_count, 16);
         end
         begin
            tick();
            tick();
            for (int i = 0; i < 17; i++) begin
               check_frame($sformatf("b2b f%0d", i), f8n1(8'(i)), 10, 4);
               if (i == 0) begin
                  chk("after pop count", fifo_count, 15);
                  chk("after pop ready", s_ready, 1);
               end
            end
         end
      join
      chk("b2b busy end", tx_busy, 0);
      chk("b2b count end", fifo_count, 0);

      push(8'h11);
      push(8'h22);
      push(8'h33);
      push(8'h44);
      chk("mid queued", fifo_count, 3);
      repeat (15) tick();
      chk("mid data3 low", tx_out, 0);
      #5 rst_n = 1'b0;
      #1;
      chk("mid rst tx", tx_out, 1);
      chk("mid rst count", fifo_count, 0);
      chk("mid rst busy", tx_busy, 0);
      #3 rst_n = 1'b1;
      begin
         logic quiet = 1'b1;
         for (int i = 0; i < 60; i++) begin
            tick();
            if (tx_out !== 1'b1 || tx_busy !== 1'b0 || fifo_count !== 5'd0) quiet = 1'b0;
         end
         chk("mid no resume", quiet, 1);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
